llc_output_encoder: RTL and testbench

- Transmit-side counterpart to the LLC input decoder; sits between the LLC core FSM and the four outgoing NoC/memory channels.
- Accepts single-cycle send commands from the core and buffers each in a per-channel 2-entry FIFO.
- Drives valid/ready handshakes toward the interconnect.
- Tracks outstanding memory reads and reports an idle condition used by the core before resuming reset or flush.

---
 rtl/llc_output_encoder_pkg.sv | 17 +
 rtl/llc_out_fifo2.sv | 54 +++++
 rtl/llc_output_encoder.sv | 89 ++++++++
 tb/tb_llc_output_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/llc_output_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : llc_output_encoder_pkg
// Description : Shared LLC constants for the outgoing channel encoder.
// Revision    : 1.0 - initial release
// ============================================================================
package llc_output_encoder_pkg;

    localparam int CH_RSP_OUT     = 0;
    localparam int CH_FWD_OUT     = 1;
    localparam int CH_MEM_REQ     = 2;
    localparam int CH_DMA_RSP_OUT = 3;

    localparam int MAX_MEM_RD_DEF = 4;

endpackage
`default_nettype wire

// File: rtl/llc_out_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : llc_out_fifo2
// Description : Two-entry valid/ready FIFO with registered full status.
// Revision    : 1.0 - initial release
// ============================================================================
module llc_out_fifo2 #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq,
    input  logic [DATA_W-1:0] enq_data,
    output logic              full,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_head;
    logic              r_tail;
    logic [1:0]        r_count;
    logic              w_push;
    logic              w_pop;

    // Push looks only at the stored count, so a same-cycle pop never frees a full slot.
    assign w_push = enq && (r_count != 2'd2);
    assign w_pop  = (r_count != 2'd0) && ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= 1'b0;
            r_tail  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) r_tail <= ~r_tail;
            if (w_pop)  r_head <= ~r_head;
            r_count <= r_count + 2'(w_push) - 2'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= enq_data;
    end

    assign full  = (r_count == 2'd2);
    assign valid = (r_count != 2'd0);
    assign data  = valid ? r_mem[r_head] : '0;
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/llc_output_encoder.sv
`default_nettype none
// ============================================================================
// Module      : llc_output_encoder
// Description : Per-channel output buffering, memory-read credit and idle status.
// Revision    : 1.0 - initial release
// ============================================================================
module llc_output_encoder
    import llc_output_encoder_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int NUM_CH     = 4,
    parameter int MAX_MEM_RD = MAX_MEM_RD_DEF,
    parameter int CNT_W      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        send,
    input  logic [NUM_CH*DATA_W-1:0] send_data,
    input  logic                     send_is_read,
    input  logic                     mem_rd_done,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        ch_full,
    output logic                     mem_rd_avail,
    output logic                     all_idle,
    output logic                     send_err
);

    localparam logic [CNT_W-1:0] c_max_rd = CNT_W'(MAX_MEM_RD);

    logic [CNT_W-1:0]  r_mem_rd_cnt;
    logic              r_send_err;
    logic [NUM_CH-1:0] w_enq;
    logic [1:0]        w_count [NUM_CH];
    logic [NUM_CH-1:0] w_ch_empty;
    logic              w_rd_inc;
    logic              w_rd_block;
    logic              w_rd_underflow;

    // A read with no credit left is dropped before reaching the FIFO.
    assign w_rd_block = send[CH_MEM_REQ] && send_is_read && !mem_rd_avail;
    assign w_rd_inc   = send[CH_MEM_REQ] && send_is_read && !ch_full[CH_MEM_REQ] && mem_rd_avail;
    assign w_rd_underflow = mem_rd_done && !w_rd_inc && (r_mem_rd_cnt == '0);

    always_comb begin
        w_enq = send;
        w_enq[CH_MEM_REQ] = send[CH_MEM_REQ] && !w_rd_block;
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            llc_out_fifo2 #(
                .DATA_W (DATA_W)
            ) u_fifo (
                .clk      (clk),
                .rst      (rst),
                .enq      (w_enq[gi]),
                .enq_data (send_data[gi*DATA_W +: DATA_W]),
                .full     (ch_full[gi]),
                .valid    (out_valid[gi]),
                .ready    (out_ready[gi]),
                .data     (out_data[gi*DATA_W +: DATA_W]),
                .count    (w_count[gi])
            );
            assign w_ch_empty[gi] = (w_count[gi] == 2'd0);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_rd_cnt <= '0;
            r_send_err   <= 1'b0;
        end else begin
            if (w_rd_inc && !mem_rd_done)
                r_mem_rd_cnt <= r_mem_rd_cnt + 1'b1;
            else if (!w_rd_inc && mem_rd_done && (r_mem_rd_cnt != '0))
                r_mem_rd_cnt <= r_mem_rd_cnt - 1'b1;
            if ((|(send & ch_full)) || w_rd_block || w_rd_underflow)
                r_send_err <= 1'b1;
        end
    end

    assign mem_rd_avail = (r_mem_rd_cnt < c_max_rd);
    assign all_idle     = (&w_ch_empty) && (r_mem_rd_cnt == '0);
    assign send_err     = r_send_err;

endmodule
`default_nettype wire

// File: tb/tb_llc_output_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_llc_output_encoder
// Description : Randomized and directed bench against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_llc_output_encoder;

    localparam int DW = 64;
    localparam int NC = 4;
    localparam int MAXRD = 4;

    logic             clk;
    logic             rst;
    logic [NC-1:0]    send;
    logic [NC*DW-1:0] send_data;
    logic             send_is_read;
    logic             mem_rd_done;
    logic [NC-1:0]    out_valid;
    logic [NC-1:0]    out_ready;
    logic [NC*DW-1:0] out_data;
    logic [NC-1:0]    ch_full;
    logic             mem_rd_avail;
    logic             all_idle;
    logic             send_err;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: in-order message lists, outstanding-read tally, sticky error
    logic [DW-1:0] m_q [NC][$];
    int            m_rd;
    bit            m_err;

    llc_output_encoder #(
        .DATA_W     (DW),
        .NUM_CH     (NC),
        .MAX_MEM_RD (MAXRD),
        .CNT_W      (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .send         (send),
        .send_data    (send_data),
        .send_is_read (send_is_read),
        .mem_rd_done  (mem_rd_done),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .ch_full      (ch_full),
        .mem_rd_avail (mem_rd_avail),
        .all_idle     (all_idle),
        .send_err     (send_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        bit idle;
        idle = (m_rd == 0);
        for (int i = 0; i < NC; i++) begin
            check($sformatf("valid[%0d]", i), 64'(out_valid[i]), 64'(m_q[i].size() != 0));
            check($sformatf("data[%0d]", i), out_data[i*DW +: DW],
                  (m_q[i].size() != 0) ? m_q[i][0] : 64'h0);
            check($sformatf("full[%0d]", i), 64'(ch_full[i]), 64'(m_q[i].size() == 2));
            if (m_q[i].size() != 0) idle = 1'b0;
        end
        check("mem_rd_avail", 64'(mem_rd_avail), 64'(m_rd < MAXRD));
        check("all_idle", 64'(all_idle), 64'(idle));
        check("send_err", 64'(send_err), 64'(m_err));
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) m_q[i].delete();
        m_rd  = 0;
        m_err = 1'b0;
    endtask

    // Called just after a falling edge: check, drive, advance the model one clock.
    task automatic step(input logic [NC-1:0] s, input logic [NC-1:0] rdy,
                        input logic rd, input logic done, input logic [NC*DW-1:0] d);
        bit inc;
        bit block;
        check_all();
        send = s; out_ready = rdy; send_is_read = rd; mem_rd_done = done; send_data = d;
        block = s[2] && rd && (m_rd >= MAXRD);
        inc   = s[2] && rd && (m_q[2].size() < 2) && (m_rd < MAXRD);
        for (int i = 0; i < NC; i++) begin
            bit accept;
            accept = s[i] && (m_q[i].size() < 2) && !(i == 2 && block);
            if (s[i] && m_q[i].size() == 2) m_err = 1'b1;
            if (m_q[i].size() != 0 && rdy[i]) void'(m_q[i].pop_front());
            if (accept) m_q[i].push_back(d[i*DW +: DW]);
        end
        if (block) m_err = 1'b1;
        if (inc && !done) m_rd++;
        else if (!inc && done) begin
            if (m_rd == 0) m_err = 1'b1;
            else m_rd--;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        send = '0; mem_rd_done = 1'b0; send_is_read = 1'b0;
        model_clear();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b1;
    endtask

    function automatic logic [NC*DW-1:0] ch_word(input int ch, input logic [DW-1:0] v);
        logic [NC*DW-1:0] w;
        w = '0;
        w[ch*DW +: DW] = v;
        return w;
    endfunction

    initial begin
        rst = 1'b0; send = '0; send_data = '0; send_is_read = 1'b0;
        mem_rd_done = 1'b0; out_ready = '0;
        model_clear();
        #1;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // single send on ch0
        step(4'b0001, 4'b1111, 1'b0, 1'b0, ch_word(0, 64'hA5));
        step(4'b0000, 4'b1111, 1'b0, 1'b0, '0);
        step(4'b0000, 4'b1111, 1'b0, 1'b0, '0);

        // backpressure on ch1, third send dropped
        step(4'b0010, 4'b0000, 1'b0, 1'b0, ch_word(1, 64'h11));
        step(4'b0010, 4'b0000, 1'b0, 1'b0, ch_word(1, 64'h22));
        step(4'b0010, 4'b0000, 1'b0, 1'b0, ch_word(1, 64'h33));
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b1111, 1'b0, 1'b0, '0);

        // streaming on ch3
        for (int k = 0; k < 8; k++)
            step(4'b1000, 4'b1111, 1'b0, 1'b0, ch_word(3, 64'h300 + 64'(k)));
        step(4'b0000, 4'b1111, 1'b0, 1'b0, '0);

        // underflow at zero count, then read credit exhaustion
        do_reset();
        step(4'b0000, 4'b1111, 1'b0, 1'b1, '0);
        do_reset();
        for (int k = 0; k < 5; k++)
            step(4'b0100, 4'b1111, 1'b1, 1'b0, ch_word(2, 64'hD0 + 64'(k)));
        step(4'b0100, 4'b1111, 1'b1, 1'b1, ch_word(2, 64'hE0));
        step(4'b0100, 4'b1111, 1'b0, 1'b0, ch_word(2, 64'hF0));
        step(4'b0000, 4'b1111, 1'b0, 1'b0, '0);
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b1111, 1'b0, 1'b1, '0);

        // reset mid-burst with two entries held on ch1
        step(4'b0010, 4'b0000, 1'b0, 1'b0, ch_word(1, 64'hAA));
        step(4'b0010, 4'b0000, 1'b0, 1'b0, ch_word(1, 64'hBB));
        do_reset();
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b1111, 1'b0, 1'b0, '0);

        // randomized traffic
        for (int k = 0; k < 2000; k++) begin
            logic [NC*DW-1:0] d;
            for (int i = 0; i < NC; i++) d[i*DW +: DW] = {$urandom, $urandom};
            step(4'($urandom), 4'($urandom | $urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), d);
            if (k == 1000) do_reset();
        end
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
